// File: rtl/pc_trap_unit.sv
// pc_trap_unit: program counter with boot vector, trap entry/return,
// misaligned-target trapping, double-trap halt and an advance counter.
//
// state   | meaning
// --------+---------------------------------------------------------
// RUN     | normal sequential / branch fetch
// HANDLER | trap handler executing, epc/mcause hold the trap record
// HALTED  | double trap seen; everything frozen until reset
module pc_trap_unit #(
    parameter int XLEN           = 32,
    parameter int CAUSE_W        = 4,
    parameter bit VECTORED       = 1'b0,
    parameter int MISALIGN_CAUSE = 0,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    initial_address,
    input  logic               tr,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [XLEN-1:0]    trap_base,
    input  logic               mret,
    input  logic               br_taken,
    input  logic [XLEN-1:0]    br_target,
    input  logic               stall,
    output logic [XLEN-1:0]    pc,
    output logic               pc_valid,
    output logic [XLEN-1:0]    epc,
    output logic [CAUSE_W-1:0] mcause,
    output logic               in_trap,
    output logic               halted,
    output logic [CNT_W-1:0]   adv_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [XLEN-1:0]    pc_nx, epc_nx;
    logic [CAUSE_W-1:0] mcause_nx;
    logic               count_en;
    logic               out_of_reset;
    logic               misaligned;
    logic               trap_req;
    logic [CAUSE_W-1:0] entry_cause;
    logic [XLEN-1:0]    trap_target;

    localparam logic [CAUSE_W-1:0] MIS_CAUSE = CAUSE_W'(MISALIGN_CAUSE);

    // Trap entry inputs: an explicit request wins over a misaligned redirect.
    always_comb begin
        misaligned  = br_taken && (br_target[1:0] != 2'b00);
        trap_req    = tr || misaligned;
        entry_cause = tr ? trap_cause : MIS_CAUSE;
        trap_target = {trap_base[XLEN-1:2], 2'b00};
        if (VECTORED) begin
            trap_target = trap_target + (XLEN'(entry_cause) << 2);
        end
    end

    // Next-state / next-PC selection in priority order.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        epc_nx    = epc;
        mcause_nx = mcause;
        count_en  = 1'b0;
        case (state)
            HANDLER: begin
                count_en = 1'b1;
                if (trap_req) begin
                    // second trap while handling the first: freeze the record
                    state_nx = HALTED;
                end else if (mret) begin
                    pc_nx    = epc;
                    state_nx = RUN;
                end else if (stall) begin
                    count_en = 1'b0;
                end else if (br_taken) begin
                    pc_nx = br_target;
                end else begin
                    pc_nx = pc + XLEN'(4);
                end
            end
            RUN: begin
                count_en = 1'b1;
                if (trap_req) begin
                    epc_nx    = pc;
                    mcause_nx = entry_cause;
                    pc_nx     = trap_target;
                    state_nx  = HANDLER;
                end else if (stall) begin
                    count_en = 1'b0;
                end else if (br_taken) begin
                    pc_nx = br_target;
                end else begin
                    pc_nx = pc + XLEN'(4);
                end
            end
            default: begin
                state_nx = HALTED;
            end
        endcase
    end

    // Registers with synchronous active-low reset; boot PC reloads every reset cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            pc           <= initial_address;
            epc          <= '0;
            mcause       <= '0;
            adv_count    <= '0;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            epc          <= epc_nx;
            mcause       <= mcause_nx;
            out_of_reset <= 1'b1;
            if (count_en) begin
                adv_count <= adv_count + CNT_W'(1);
            end
        end
    end

    // Status outputs decode purely from registered state.
    always_comb begin
        in_trap  = (state == HANDLER);
        halted   = (state == HALTED);
        pc_valid = out_of_reset && (state != HALTED);
    end

endmodule

// File: doc/pc_trap_unit.md
Name: pc_trap_unit

Overview:
- Parametrised program-counter and trap-sequencing unit for the RISC-V cores (monocycle and later multicycle/pipelined).
- Replaces the fixed reset-vector PC logic of the single-cycle core.
- Adds a boot address loaded under reset, a trap request (`tr`) with saved EPC/cause, vectored or direct trap entry, `mret` return, stall, misaligned-target detection, double-trap halt, and an advance counter.

Parameters:
- XLEN, 32, address/PC width.
- CAUSE_W, 4, width of trap cause.
- VECTORED, 0, 0 = all traps go to trap_base; 1 = trap_base + 4*cause.
- MISALIGN_CAUSE, 0, cause code written on a misaligned branch target.
- CNT_W, 32, width of the advance counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- initial_address  input  XLEN  boot PC, loaded every cycle reset is low.
- tr  input  1  trap request, sampled on the clock edge.
- trap_cause  input  CAUSE_W  cause accompanying tr.
- trap_base  input  XLEN  trap base address; bits [1:0] are ignored and treated as 0.
- mret  input  1  return from trap.
- br_taken  input  1  branch/jump redirect.
- br_target  input  XLEN  redirect target.
- stall  input  1  hold PC.
- pc  output  XLEN  current fetch address.
- pc_valid  output  1  pc is a legal fetch address this cycle.
- epc  output  XLEN  PC saved at trap entry.
- mcause  output  CAUSE_W  cause saved at trap entry.
- in_trap  output  1  handler executing.
- halted  output  1  double trap occurred; sticky until reset.
- adv_count  output  CNT_W  number of cycles in which pc changed under RUN/HANDLER.

Behaviour:
- State machine: RUN, HANDLER, HALTED.
- Reset (reset=0 at a clock edge):
  - pc <= initial_address; state <= RUN.
  - epc = 0, mcause = 0, in_trap = 0, halted = 0, adv_count = 0.
  - pc_valid = 0 while reset is low.
  - Reset asserted mid-trap or in HALTED aborts everything identically.
- pc_valid:
  - 1 in RUN and HANDLER.
  - 0 in HALTED and during reset.
- Next-PC priority (highest first), per edge with reset=1:
  1. HALTED: all outputs frozen; every input ignored.
  2. tr=1 in HANDLER: state <= HALTED, halted <= 1; pc, epc and mcause unchanged.
  3. tr=1 in RUN: epc <= pc; mcause <= trap_cause; pc <= trap target; state <= HANDLER. tr overrides stall, mret and br_taken.
  4. br_taken=1 with br_target[1:0] != 0: handled as a trap (RUN) or double trap (HANDLER); epc <= pc; mcause <= MISALIGN_CAUSE; target is computed as if cause = MISALIGN_CAUSE.
  5. mret=1 in HANDLER: pc <= epc; state <= RUN.
  6. mret=1 in RUN: ignored; falls through to the items below.
  7. stall=1: pc held.
  8. br_taken=1 with an aligned target: pc <= br_target.
  9. Otherwise: pc <= pc + 4.
- Trap target:
  - VECTORED=0: {trap_base[XLEN-1:2], 2'b00}.
  - VECTORED=1: the same aligned base + (cause << 2).
- Arithmetic:
  - All sums are modulo 2^XLEN.
  - pc = 0xFFFFFFFC + 4 wraps to 0 with no flag.
- adv_count:
  - Increments by 1 on every edge where state is not HALTED, reset=1, and the case is not stall-hold.
  - Trap entry, mret, branch and sequential all count.
  - Wraps at 2^CNT_W.
- Latency: every effect is visible on outputs one edge after sampling. No combinational input-to-output path.
- stall does not block mret or a misaligned-branch trap.

Test Plan:
- Boot:
  - Stimulus: initial_address=0x100, reset=0 for 1 cycle, release, run 4 edges.
  - Required: pc=0x100 with pc_valid=0 during reset; then 0x104, 0x108, 0x10C, 0x110; adv_count=4.
- Trap/return, VECTORED=0:
  - Stimulus: at pc=0x108, tr=1, trap_cause=3, trap_base=0x203.
  - Required: pc=0x200, epc=0x108, mcause=3, in_trap=1. mret one cycle later → pc=0x108, in_trap=0.
- Vectored entry, VECTORED=1:
  - Stimulus: trap_base=0x400, cause=5.
  - Required: pc=0x414.
- Priority:
  - Stimulus: tr=1, stall=1 and br_taken=1 (target 0x80) in the same cycle.
  - Required: trap taken, branch ignored, adv_count+1.
  - Stimulus: stall alone for 3 cycles.
  - Required: pc constant, adv_count constant.
- Misaligned branch and double trap:
  - Stimulus: br_target=0x82, br_taken=1 in RUN.
  - Required: mcause=0, epc=old pc, in_trap=1.
  - Stimulus: then tr=1 in HANDLER.
  - Required: halted=1, pc_valid=0, pc frozen for 5 cycles despite any input.
  - Stimulus: reset low.
  - Required: recovery to initial_address.
- Wrap and ignored mret:
  - Stimulus: initial_address=0xFFFFFFF8, 3 edges.
  - Required: pc = 0xFFFFFFFC, 0x0, 0x4.
  - Stimulus: mret in RUN.
  - Required: pc simply increments.
